muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
- Iterative sequencer for the RV32M multiply/divide operations; sits beside the single-cycle ALU in EX.
- Accepts one operation through a valid/ready request port.
- Runs a radix-2 shift-add (multiply) or restoring shift-subtract (divide) datapath for XLEN cycles, applies sign fix-up, then holds the result on a valid/ready response port.
- Stalls the pipeline through busy; can be aborted by flush.

Parameters:
XLEN, 32, operand/result width; power of two, at least 8

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  abort current operation (pipeline redirect)
req_valid  in  1  request present
req_ready  out  1  sequencer idle, request accepted when req_valid && req_ready
funct3  in  3  M-ext op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1  in  XLEN  operand A / dividend
rs2  in  XLEN  operand B / divisor
resp_valid  out  1  result available
resp_ready  in  1  consumer takes result
result  out  XLEN  operation result
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock, reset and reset values
  - Single clock, clk. Reset is synchronous and active-high on rst.
  - Reset gives state IDLE, resp_valid 0, result 0, busy 0, req_ready 1, counter 0.
- State machine: IDLE, CALC, FIXUP, DONE.
- IDLE
  - req_ready = 1.
  - On handshake, latch funct3 and sign flags.
  - Latch operand magnitudes: negate rs1 if its MSB is set for MULH/MULHSU/DIV/REM; negate rs2 if its MSB is set for MULH/DIV/REM.
  - Load counter = XLEN and go to CALC.
  - Special cases go directly to DONE, with resp_valid high on the cycle after the handshake:
    - Divide by zero (rs2 == 0, DIV/DIVU/REM/REMU): quotient all-ones, remainder rs1.
    - Signed overflow (DIV/REM, rs1 = 1 followed by zeros, rs2 = all-ones): quotient rs1, remainder 0.
- CALC
  - One iteration per cycle; decrement counter.
  - At counter == 1 → FIXUP, after exactly XLEN iterations.
  - Multiply: 2*XLEN-bit accumulator.
  - Divide: XLEN-bit remainder plus quotient register.
- FIXUP
  - Negate the 2*XLEN product when operand signs differ (MULH; MULHSU uses rs1 sign only).
  - Negate the quotient when dividend and divisor signs differ.
  - Negate the remainder when the dividend is negative.
  - Select: low half for MUL, high half for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU.
  - Register into result, set resp_valid, go to DONE.
- DONE
  - result and resp_valid stay stable until resp_ready.
  - On resp_valid && resp_ready: resp_valid 0 next cycle, state IDLE.
  - req_ready stays low in DONE: no back-to-back accept in the response cycle.
- Latency: handshake at edge N → CALC cycles N+1..N+XLEN → FIXUP N+XLEN+1 → resp_valid visible from N+XLEN+2 (34 cycles for XLEN = 32).
- Boundary conditions
  - flush in any state → IDLE next cycle, resp_valid 0, result unchanged.
  - flush has priority over a simultaneous request (no accept) and over resp_ready.
  - rst has priority over flush.
  - req_valid while busy is ignored; it is not queued.
  - funct3 is always one of the eight M ops; no illegal encoding.
- Arithmetic: all internal arithmetic modulo 2^XLEN or 2^(2*XLEN); no X propagation from unused operand bits.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined:
  - Multiply in CALC jumps to FIXUP once the remaining shifted multiplier magnitude is zero.
  - Latency becomes (number of significant multiplier bits) + 2; zero multiplier gives resp_valid at N+2.
  - Divide latency unchanged.
- Undefined: fixed XLEN-iteration latency for every operation; no early-out logic synthesized.

Test Plan:
- MUL rs1 = 7, rs2 = 6 → result 42, resp_valid exactly 34 cycles after handshake, busy high throughout, req_ready low until response taken.
- DIV rs1 = 0xFFFFFFF9 (-7), rs2 = 2 → 0xFFFFFFFD (-3); REM same operands → 0xFFFFFFFF (-1); DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases, each with resp_valid one cycle after handshake:
  - DIVU 0x12345678/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Backpressure and flush:
  - resp_ready held low 10 cycles in DONE → result and resp_valid stable.
  - Assert req_valid during DONE → not accepted.
  - resp_ready high → IDLE next cycle.
- Flush and reset during CALC:
  - flush in the 5th CALC cycle → busy 0 and req_ready 1 next cycle, no resp_valid.
  - New MUL 3 × 3 → 9.
  - rst mid-CALC → all outputs at reset values.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply, restoring divide.
// Optional MULDIV_EARLY_OUT_EN: multiply leaves CALC once the remaining multiplier is zero.
module muldiv_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int unsigned CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
    state_t state, state_nxt;

    logic [2:0]        op;
    logic              neg_a, neg_b;
    logic [CW-1:0]     count;
    logic [XLEN-1:0]   divisor;
    logic [2*XLEN-1:0] mcand, acc;
    logic [XLEN-1:0]   q, rem;

    logic              hs, is_div, sgn_a, sgn_b, a_neg_in, b_neg_in;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   a_mag_in, b_mag_in, special_res;
    logic [XLEN:0]     shifted, diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo_f, rem_f, fix_res;
    logic              last_iter;

    always_comb begin
        is_div   = funct3[2];
        sgn_a    = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
        sgn_b    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg_in = sgn_a && rs1[XLEN-1];
        b_neg_in = sgn_b && rs2[XLEN-1];
        a_mag_in = a_neg_in ? -rs1 : rs1;
        b_mag_in = b_neg_in ? -rs2 : rs2;
        div_zero = is_div && (rs2 == '0);
        div_ovf  = is_div && !funct3[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
        special  = div_zero || div_ovf;
        // funct3[1] distinguishes REM/REMU from DIV/DIVU
        if (div_zero) special_res = funct3[1] ? rs1 : '1;
        else          special_res = funct3[1] ? '0 : rs1;
    end

    // One restoring-division step: shift next dividend bit into the remainder, try subtracting
    always_comb begin
        shifted = {rem, q[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
    end

    always_comb begin
        prod  = (neg_a ^ neg_b) ? -acc : acc;
        quo_f = (neg_a ^ neg_b) ? -q : q;
        rem_f = neg_a ? -rem : rem;
        case (op)
            3'b000:                 fix_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_f;
            default:                fix_res = rem_f;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
        hs        = req_valid && (state == IDLE) && !flush;
        last_iter = (count == CW'(1));
`ifdef MULDIV_EARLY_OUT_EN
        if (!op[2] && ((q >> 1) == '0)) last_iter = 1'b1;
`endif
        case (state)
            IDLE: begin
                if (hs) begin
                    if (special) state_nxt = DONE;
`ifdef MULDIV_EARLY_OUT_EN
                    else if (!is_div && (b_mag_in == '0)) state_nxt = FIXUP;
`endif
                    else state_nxt = CALC;
                end
            end
            CALC:    if (last_iter) state_nxt = FIXUP;
            FIXUP:   state_nxt = DONE;
            DONE:    if (resp_valid && resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op         <= '0;
            neg_a      <= 1'b0;
            neg_b      <= 1'b0;
            count      <= '0;
            divisor    <= '0;
            mcand      <= '0;
            acc        <= '0;
            q          <= '0;
            rem        <= '0;
            result     <= '0;
            resp_valid <= 1'b0;
        end else if (flush) begin
            resp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        op      <= funct3;
                        neg_a   <= a_neg_in;
                        neg_b   <= b_neg_in;
                        count   <= CW'(XLEN);
                        divisor <= b_mag_in;
                        mcand   <= {{XLEN{1'b0}}, a_mag_in};
                        acc     <= '0;
                        // q holds the dividend for divides and the shifting multiplier for multiplies
                        q       <= is_div ? a_mag_in : b_mag_in;
                        rem     <= '0;
                        if (special) begin
                            result     <= special_res;
                            resp_valid <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    count <= count - CW'(1);
                    if (op[2]) begin
                        if (!diff[XLEN]) begin
                            rem <= diff[XLEN-1:0];
                            q   <= {q[XLEN-2:0], 1'b1};
                        end else begin
                            rem <= shifted[XLEN-1:0];
                            q   <= {q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        if (q[0]) acc <= acc + mcand;
                        mcand <= mcand << 1;
                        q     <= q >> 1;
                    end
                end
                FIXUP: begin
                    result     <= fix_res;
                    resp_valid <= 1'b1;
                end
                DONE: begin
                    if (resp_ready) resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
